display_scan_controller: RTL

Sequences an 8-row display scan: steps a 3-bit row index 0..7 at a programmable row period and drives a one-hot row select. A blanking interval at the start of each row suppresses ghosting. Supports continuous scanning and single-frame scanning, and reports frame boundaries to the display datapath, which loads column data per row.

---
 rtl/scan_pkg.sv | 21 ++
 rtl/scan_step_timer.sv | 43 ++++
 rtl/display_scan_controller.sv | 93 +++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the display row-scan controller: FSM states,
// row geometry and the one-hot row decode.
package scan_pkg;

  localparam int NUM_ROWS = 8;
  localparam int ROW_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  function automatic logic [NUM_ROWS-1:0] row_onehot(input logic [ROW_W-1:0] idx);
    logic [NUM_ROWS-1:0] sel;
    sel      = '0;
    sel[idx] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/scan_step_timer.sv
// Row-period cycle counter: wraps at STEP_CYCLES-1 and flags the end of the
// blanking window and the end of the row period.
module scan_step_timer #(
  parameter int STEP_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             tc,
  output logic             blank_end
);

  localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  generate
    if (STEP_CYCLES < 2) begin : g_bad_step
      $error("scan_step_timer: STEP_CYCLES must be at least 2");
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES >= STEP_CYCLES) begin : g_bad_blank
      $error("scan_step_timer: BLANK_CYCLES must be in [0, STEP_CYCLES)");
    end
    if ((64'd1 << CNT_W) < 64'(STEP_CYCLES)) begin : g_bad_width
      $error("scan_step_timer: CNT_W too narrow for STEP_CYCLES");
    end
  endgenerate

  assign tc        = (cnt == CNT_W'(STEP_CYCLES - 1));
  assign blank_end = (BLANK_CYCLES != 0) && (cnt == CNT_W'(BLANK_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// 8-row display scan sequencer with per-row blanking, continuous and
// single-frame modes, and frame boundary strobes for the column datapath.
module display_scan_controller
  import scan_pkg::*;
#(
  parameter int STEP_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                oneshot,
  output logic                busy,
  output logic [ROW_W-1:0]    row_idx,
  output logic [NUM_ROWS-1:0] row_sel,
  output logic                blank,
  output logic                last_row,
  output logic                frame_start,
  output logic                frame_done
);

  localparam state_e ROW_ENTRY = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

  state_e           state;
  logic [ROW_W-1:0] row;
  logic             single;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             blank_end;

  scan_step_timer #(
    .STEP_CYCLES  (STEP_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == IDLE),
    .cnt       (cnt),
    .tc        (tc),
    .blank_end (blank_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      row    <= '0;
      single <= 1'b0;
    end else begin
      // run seen at any point of a single frame converts it to continuous
      if (state != IDLE && run) single <= 1'b0;
      case (state)
        IDLE: begin
          if (run || oneshot) begin
            state  <= ROW_ENTRY;
            row    <= '0;
            single <= oneshot && !run;
          end
        end
        BLANK: begin
          if (blank_end) state <= DRIVE;
        end
        DRIVE: begin
          if (tc) begin
            if (row != ROW_LAST) begin
              row   <= row + 1'b1;
              state <= ROW_ENTRY;
            end else if (run && !single) begin
              row   <= '0;
              state <= ROW_ENTRY;
            end else begin
              row    <= '0;
              state  <= IDLE;
              single <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign row_idx     = row;
  assign row_sel     = (state == DRIVE) ? row_onehot(row) : '0;
  assign blank       = (state != DRIVE);
  assign last_row    = busy && (row == ROW_LAST);
  assign frame_start = busy && (row == '0) && (cnt == '0);
  assign frame_done  = (state == DRIVE) && (row == ROW_LAST) && tc;

endmodule
